// File: rtl/bus_arbiter_rr2.sv
// bus_arbiter_rr2: two-master round-robin front end for the simple bus.
// One transaction in flight; read responses are routed back to the issuer.
module bus_arbiter_rr2 #(
    parameter int unsigned RD_TIMEOUT   = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    output logic        grant_valid,
    output logic        grant_id,
    output logic        timeout_pulse
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT_R} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(RD_TIMEOUT);

    state_t      state;
    logic        last_id;
    logic [15:0] cnt;

    logic        own_valid;
    logic        own_write;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_wstrb;
    logic        in_grant;
    logic        in_wait;
    logic        expired;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        pick;

    always_comb begin
        own_valid = grant_id ? m1_valid : m0_valid;
        own_write = grant_id ? m1_write : m0_write;
        own_addr  = grant_id ? m1_addr  : m0_addr;
        own_wdata = grant_id ? m1_wdata : m0_wdata;
        own_wstrb = grant_id ? m1_wstrb : m0_wstrb;
    end

    // Tie goes to whoever did not complete the previous transaction.
    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            m0_valid && m1_valid:  pick = ~last_id;
            m1_valid && !m0_valid: pick = 1'b1;
            default:               pick = 1'b0;
        endcase
    end

    assign in_grant = (state == GRANT);
    assign in_wait  = (state == WAIT_R);

    assign s_valid = in_grant & own_valid;
    assign s_write = in_grant & own_write;
    assign s_addr  = in_grant ? own_addr  : 32'd0;
    assign s_wdata = in_grant ? own_wdata : 32'd0;
    assign s_wstrb = in_grant ? own_wstrb : 4'd0;

    assign m0_ready = in_grant & ~grant_id & s_ready;
    assign m1_ready = in_grant &  grant_id & s_ready;

    // A real response in the expiry cycle suppresses the synthetic one.
    assign expired   = in_wait & ~s_rvalid & ((cnt + 16'd1) == TIMEOUT_CNT);
    assign rsp_valid = in_wait & (s_rvalid | expired);
    assign rsp_data  = s_rvalid ? s_rdata : TIMEOUT_DATA;

    assign m0_rvalid     = rsp_valid & ~grant_id;
    assign m1_rvalid     = rsp_valid &  grant_id;
    assign m0_rdata      = m0_rvalid ? rsp_data : 32'd0;
    assign m1_rdata      = m1_rvalid ? rsp_data : 32'd0;
    assign timeout_pulse = expired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            grant_valid <= 1'b0;
            grant_id    <= 1'b0;
            cnt         <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state       <= GRANT;
                        grant_valid <= 1'b1;
                        grant_id    <= pick;
                    end
                end
                GRANT: begin
                    if (!own_valid) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else if (s_ready) begin
                        if (own_write) begin
                            last_id     <= grant_id;
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end else begin
                            cnt   <= 16'd0;
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (s_rvalid || expired) begin
                        last_id     <= grant_id;
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr2.sv
// tb_bus_arbiter_rr2: directed stimulus with a queue-based scoreboard
// for downstream requests and routed read responses.
module tb_bus_arbiter_rr2;
    typedef struct packed {
        logic        id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        to;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_valid = 0, m0_write = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic [3:0]  m0_wstrb = 0;
    logic        m0_ready, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_valid = 0, m1_write = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m1_wstrb = 0;
    logic        m1_ready, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        s_valid, s_write;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b1;
    logic        s_rvalid = 1'b0;
    logic [31:0] s_rdata = 0;
    logic        grant_valid, grant_id, timeout_pulse;

    int   checks = 0;
    int   errors = 0;
    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t er;
    rsp_t rr;

    bus_arbiter_rr2 #(.RD_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic id, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.id = id; r.wr = wr; r.addr = a; r.wdata = d; r.strb = s;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input logic id, input logic [31:0] d, input logic to);
        rsp_t r;
        r.id = id; r.data = d; r.to = to;
        exp_rsp.push_back(r);
    endtask

    task automatic drive(input logic id, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (id) begin
            m1_valid = v; m1_write = w; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end else begin
            m0_valid = v; m0_write = w; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end
    endtask

    task automatic wait_accept(input logic id);
        bit ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (id ? (m1_valid && m1_ready) : (m0_valid && m0_ready)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_wait m%0d actual=none required=accept", id);
        end
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        s_ready = 1'b1; s_rvalid = 1'b0; s_rdata = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {grant_valid, grant_id, s_valid, s_write, timeout_pulse,
                         m0_ready, m1_ready, m0_rvalid, m1_rvalid}, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_s_wstrb", s_wstrb, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        cyc();
    endtask

    // Scoreboard monitor: pops on every downstream accept and read response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected actual=%h required=none", s_addr);
                end else begin
                    er = exp_req.pop_front();
                    chk("req_id", grant_id, er.id);
                    chk("req_write", s_write, er.wr);
                    chk("req_addr", s_addr, er.addr);
                    chk("req_wdata", s_wdata, er.wdata);
                    chk("req_wstrb", s_wstrb, er.strb);
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected actual=%b%b required=00",
                             m1_rvalid, m0_rvalid);
                end else begin
                    rr = exp_rsp.pop_front();
                    chk("rsp_id", m1_rvalid, rr.id);
                    chk("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, rr.data);
                    chk("rsp_timeout", timeout_pulse, rr.to);
                end
            end
            chk("ready_excl", m0_ready & m1_ready, 0);
            if (!m0_rvalid) chk("m0_rdata_zero", m0_rdata, 0);
            if (!m1_rvalid) chk("m1_rdata_zero", m1_rdata, 0);
            if (!m0_rvalid && !m1_rvalid) chk("pulse_alone", timeout_pulse, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single write from master 0
        do_reset();
        push_req(0, 1, 32'h0001_0000, 32'h1234_5678, 4'hF);
        drive(0, 1, 1, 32'h0001_0000, 32'h1234_5678, 4'hF);
        @(negedge clk);
        chk("wr_arb_svalid", s_valid, 0);
        cyc();
        @(negedge clk);
        chk("wr_svalid", s_valid, 1);
        chk("wr_m0_ready", m0_ready, 1);
        chk("wr_m1_ready", m1_ready, 0);
        chk("wr_grant", {grant_valid, grant_id}, 2'b10);
        cyc();
        m0_valid = 0;
        @(negedge clk);
        chk("wr_grant_drop", grant_valid, 0);
        chk("wr_m0_ready_drop", m0_ready, 0);
        cyc();

        // Tie: both masters stream three writes each
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_req(0, 1, 32'h1000 + 32'(i) * 32'd4, 32'hA0 + 32'(i), 4'hF);
            push_req(1, 1, 32'h2000 + 32'(i) * 32'd4, 32'hB0 + 32'(i), 4'hF);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    drive(0, 1, 1, 32'h1000 + 32'(i) * 32'd4, 32'hA0 + 32'(i), 4'hF);
                    wait_accept(0);
                end
                drive(0, 0, 0, 0, 0, 0);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    drive(1, 1, 1, 32'h2000 + 32'(j) * 32'd4, 32'hB0 + 32'(j), 4'hF);
                    wait_accept(1);
                end
                drive(1, 0, 0, 0, 0, 0);
            end
        join
        cyc();

        // Read routing to master 1, m0 pending behind it
        do_reset();
        push_req(1, 0, 32'h0002_0004, 0, 0);
        push_rsp(1, 32'hCAFE_0001, 0);
        drive(1, 1, 0, 32'h0002_0004, 0, 0);
        cyc();
        push_req(0, 1, 32'h0000_4000, 32'h77, 4'h3);
        drive(0, 1, 1, 32'h0000_4000, 32'h77, 4'h3);
        @(negedge clk);
        chk("rd_m1_ready", m1_ready, 1);
        chk("rd_m0_ready", m0_ready, 0);
        cyc();
        m1_valid = 0;
        cyc();
        cyc();
        s_rvalid = 1; s_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("rd_m1_rvalid", m1_rvalid, 1);
        chk("rd_m1_rdata", m1_rdata, 32'hCAFE_0001);
        chk("rd_m0_rvalid", m0_rvalid, 0);
        cyc();
        s_rvalid = 0; s_rdata = 0;
        @(negedge clk);
        chk("rd_m1_rvalid_once", m1_rvalid, 0);
        cyc();
        @(negedge clk);
        chk("rd_next_grant", {grant_valid, grant_id}, 2'b10);
        chk("rd_next_m0_ready", m0_ready, 1);
        cyc();
        m0_valid = 0;
        cyc();

        // Timeout with RD_TIMEOUT=4
        do_reset();
        push_req(0, 0, 32'h0000_3000, 0, 0);
        push_rsp(0, 32'hDEAD_BEEF, 1);
        drive(0, 1, 0, 32'h0000_3000, 0, 0);
        cyc();
        cyc();
        m0_valid = 0;
        @(negedge clk);
        chk("to_early_c2", timeout_pulse, 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("to_early_c4", {timeout_pulse, m0_rvalid}, 0);
        cyc();
        @(negedge clk);
        chk("to_rvalid", m0_rvalid, 1);
        chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_pulse", timeout_pulse, 1);
        cyc();
        @(negedge clk);
        chk("to_pulse_once", {timeout_pulse, m0_rvalid}, 0);
        cyc();
        s_rvalid = 1; s_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("to_late_discard", {m0_rvalid, m1_rvalid}, 0);
        cyc();
        s_rvalid = 0; s_rdata = 0;
        cyc();

        // Response coincides with the timeout cycle
        do_reset();
        push_req(1, 0, 32'h0000_5000, 0, 0);
        push_rsp(1, 32'h1111_2222, 0);
        drive(1, 1, 0, 32'h0000_5000, 0, 0);
        cyc();
        cyc();
        m1_valid = 0;
        cyc();
        cyc();
        cyc();
        s_rvalid = 1; s_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("co_rvalid", m1_rvalid, 1);
        chk("co_rdata", m1_rdata, 32'h1111_2222);
        chk("co_pulse", timeout_pulse, 0);
        cyc();
        s_rvalid = 0; s_rdata = 0;
        cyc();

        // Reset mid-read, late response discarded, next tie goes to m0
        do_reset();
        push_req(0, 0, 32'h0000_6000, 0, 0);
        drive(0, 1, 0, 32'h0000_6000, 0, 0);
        cyc();
        cyc();
        m0_valid = 0;
        rst_n = 0;
        cyc();
        rst_n = 1;
        s_rvalid = 1; s_rdata = 32'h9999_0000;
        @(negedge clk);
        chk("mr_ctrl", {grant_valid, grant_id, s_valid, timeout_pulse,
                        m0_ready, m1_ready, m0_rvalid, m1_rvalid}, 0);
        chk("mr_rdata", m0_rdata | m1_rdata, 0);
        cyc();
        s_rvalid = 0; s_rdata = 0;
        push_req(0, 1, 32'h0000_7000, 32'h7, 4'h1);
        push_req(1, 1, 32'h0000_8000, 32'h8, 4'h2);
        drive(0, 1, 1, 32'h0000_7000, 32'h7, 4'h1);
        drive(1, 1, 1, 32'h0000_8000, 32'h8, 4'h2);
        cyc();
        @(negedge clk);
        chk("mr_tie_grant", {grant_valid, grant_id}, 2'b10);
        cyc();
        m0_valid = 0;
        wait_accept(1);
        m1_valid = 0;
        cyc();
        cyc();

        chk("req_queue_empty", exp_req.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter_rr2.md
# bus_arbiter_rr2

Two-master round-robin arbiter that shares the single simple-bus master port of the SoC interconnect between two requesters, e.g. the testbench/CPU port and a second bus master such as a debug bridge or inference sequencer. It sits directly in front of `bus_interconnect`. It serialises transactions so that exactly one is in flight, and routes each read response back to its issuer. A read-response timeout guarantees forward progress if a slave never returns `rvalid`.

## Interface
- `RD_TIMEOUT`, default 255: cycles in WAIT_R before a synthetic response is generated. Legal range is 1..65535.
- `TIMEOUT_DATA`, default 32'hDEAD_BEEF: rdata returned on timeout.
- `clk  in  1`: single clock. All logic is on the rising edge.
- `rst_n  in  1`: reset, synchronous and active-low.
- `m0_valid, m0_write  in  1 each`: master 0 request and direction.
- `m0_addr, m0_wdata  in  32 each`: master 0 address and write data.
- `m0_wstrb  in  4`: master 0 byte strobes.
- `m0_ready  out  1`: master 0 request accepted this cycle.
- `m0_rvalid  out  1`: master 0 read data valid, single-cycle pulse.
- `m0_rdata  out  32`: master 0 read data.
- `m1_*`: same eight signals for master 1.
- `s_valid, s_write  out  1 each`: downstream request and direction, to the interconnect.
- `s_addr, s_wdata  out  32 each`: downstream address and write data.
- `s_wstrb  out  4`: downstream byte strobes.
- `s_ready  in  1`: downstream accept.
- `s_rvalid  in  1`: downstream read response valid.
- `s_rdata  in  32`: downstream read data.
- `grant_valid  out  1`: a master currently owns the downstream port.
- `grant_id  out  1`: owning master (0/1). Meaningful only when `grant_valid`=1.
- `timeout_pulse  out  1`: one-cycle pulse when a read times out.

## Operation
- Bus protocol, for each master and for `s_*`:
  - A request is held stable from `valid` rising until the accept cycle, which is `valid && ready`.
  - A write completes at accept.
  - A read completes when `rvalid` is pulsed, no earlier than the cycle after accept.
- States:
  - IDLE: no owner.
  - GRANT: owner's request is forwarded downstream.
  - WAIT_R: read accepted, waiting for the response.
- IDLE:
  - With no requests, stay in IDLE.
  - With one requester, grant it.
  - With both requesting, grant the master that is not `last_id`.
  - The grant is registered: go to GRANT next cycle with `grant_id` set and `grant_valid`=1.
- GRANT:
  - `s_valid`/`s_write`/`s_addr`/`s_wdata`/`s_wstrb` are driven combinationally from the owner's inputs.
  - The owner's `ready` = `s_ready`. The non-owner's `ready` = 0.
  - On accept with write: `last_id`←owner, go to IDLE.
  - On accept with read: clear the timeout counter, go to WAIT_R.
  - If the owner drops `valid` without accept (protocol error), go to IDLE without updating `last_id`.
  - `s_rvalid` is ignored in GRANT.
- WAIT_R:
  - `s_valid`=0.
  - Owner `rvalid`/`rdata` = `s_rvalid`/`s_rdata`. The non-owner sees `rvalid`=0 and `rdata`=0.
  - On `s_rvalid`: `last_id`←owner, go to IDLE.
  - Otherwise the counter increments each cycle. When it reaches `RD_TIMEOUT`, in that same cycle:
    - drive owner `rvalid`=1 with `rdata`=`TIMEOUT_DATA`;
    - assert `timeout_pulse`=1;
    - set `last_id`←owner;
    - go to IDLE.
  - If `s_rvalid` coincides with the timeout cycle, the real response wins and `timeout_pulse` stays 0.
- Requests from either master are not granted while in GRANT or WAIT_R; a waiting master holds `valid`.
- Any `s_rvalid` arriving in IDLE (e.g. a late response after a timeout or after a reset) is discarded and forwarded to nobody.
- Counter width is 16 bits. The counter never wraps, because it leaves WAIT_R at `RD_TIMEOUT`.

## Timing
- Reset values:
  - state = IDLE, `last_id` = 1, so master 0 wins the first tie.
  - `grant_valid`, `grant_id`, `s_valid`, `s_write`, `timeout_pulse`, all `m*_ready`, all `m*_rvalid` = 0.
  - `s_addr`, `s_wdata`, `s_wstrb`, `m*_rdata` = 0.
- Reset asserted mid-transaction returns the block to IDLE on the next edge. Any downstream response still in flight is then discarded.
- Latency:
  - Request to downstream `s_valid` is 1 cycle (the arbitration cycle).
  - Write throughput is at best one write per 2 cycles per transaction.
  - Read latency is 1 + downstream accept latency + downstream response latency.
- `s_*` and `m*_ready` are combinational from the owner's inputs only in GRANT, and are 0 in all other states. `m*_rdata` is 0 whenever that master's `rvalid` is 0.
- `timeout_pulse` and the synthetic `rvalid` are asserted in the same cycle, for exactly one cycle.

## Test plan
- **Single write from master 0.** Stimulus: after reset, m0 write addr 0x0001_0000, data 0x1234_5678, wstrb 0xF, with `s_ready`=1. Required: `s_valid` high exactly 1 cycle after `m0_valid` with matching fields; `m0_ready` pulses once; `m1_ready` stays 0; `grant_valid` falls the next cycle.
- **Tie, round-robin.** Stimulus: m0 and m1 each issue 3 writes back-to-back, both requesting continuously. Required: grant order 0,1,0,1,0,1, with no master starved.
- **Read routing.** Stimulus: m1 reads 0x0002_0004; the slave returns 0xCAFE_0001 three cycles after accept. Required: `m1_rvalid`=1 with that data for exactly one cycle; `m0_rvalid` stays 0; m0's pending request is granted the cycle after the response.
- **Timeout.** Stimulus: `RD_TIMEOUT`=4; m0 read, and `s_rvalid` is never asserted. Required: 4 cycles after accept, `m0_rvalid`=1 with `m0_rdata`=0xDEAD_BEEF and `timeout_pulse`=1; a late `s_rvalid` 2 cycles later produces no `rvalid` on either master.
- **Coincident response.** Stimulus: `s_rvalid` arrives exactly in the timeout cycle. Required: the real data is returned and `timeout_pulse`=0.
- **Reset mid-read.** Stimulus: `rst_n` asserted low for 1 cycle while in WAIT_R; `s_rvalid` arrives afterwards. Required: all outputs at their reset values; the response is discarded; the next tie grants m0.
